ym_dbg_write: RTL and testbench
===============================

Name: ym_dbg_write

Overview:
- Serial-in, parallel-out debug/test register chain; it is the write-side counterpart of the serial debug read chain.
- It receives a framed bit stream, LSB first, clocked by the two-phase enables c1/c2.
- After DATA_WIDTH bits it commits the assembled word to a parallel output register and pulses done.
- Chains of blocks are built by connecting sout to the next block's sin; it is used to inject test values into chip internals.

Parameters:
- DATA_WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- MCLK  input  1  master clock; all state updates on posedge MCLK.
- reset  input  1  asynchronous, active-low reset.
- c1  input  1  phase-1 enable; captures one serial bit.
- c2  input  1  phase-2 enable; master-to-slave transfer.
- start  input  1  frame start; qualified by c1; marks the first bit of a frame.
- sin  input  1  serial data in, LSB first.
- sout  output  1  serial chain out, equal to slave[0].
- data_out  output  DATA_WIDTH  last committed word.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-MCLK-cycle pulse on commit.

Behaviour:
- Interface: one clock, MCLK. reset is asynchronous and active-low.
- Reset (reset=0, asynchronous): master M, slave S, data_out, bit counter cnt, done all 0; state IDLE; busy 0; sout 0. Leaving reset takes effect at the first posedge MCLK with reset=1.
- Storage: master M[DATA_WIDTH-1:0], slave S[DATA_WIDTH-1:0], cnt of width clog2(DATA_WIDTH+1).
- Capture (c1 capture enabled): M <= {sin, S[DATA_WIDTH-1:1]}.
- Transfer: on c2, S <= M.
- c1 and c2 high on the same edge: capture uses old S and transfer uses old M; both happen.
- Drivers must alternate c1/c2. Two c1 captures without an intervening c2 overwrite the same bit position; cnt still increments; resulting data is unspecified.
- Bit order: the first captured bit ends in bit 0 after DATA_WIDTH capture/transfer pairs.
- States: IDLE, SHIFT, COMMIT_WAIT.
- IDLE:
  - c1 & start: capture, cnt <= 1, go to SHIFT.
  - c1 without start: ignored (no capture, cnt unchanged).
  - c2: transfer still occurs, so sout keeps draining the chain.
- SHIFT:
  - c1 & start: restart the frame. Partial data is discarded logically; capture sin as new bit 0, cnt <= 1.
  - c1 & ~start: capture, cnt <= cnt+1. If the new cnt == DATA_WIDTH, go to COMMIT_WAIT.
  - c2: transfer.
- COMMIT_WAIT:
  - c1 ignored, including with start (no capture, no restart).
  - On c2: S <= M, data_out <= M (the same value), done <= 1, cnt <= 0, go to IDLE.
- done: registered; high for exactly the one MCLK cycle following the commit edge, otherwise 0.
  - A commit edge that also carries c1 & start is allowed. It is processed as the commit only; that start is ignored because the state was COMMIT_WAIT.
- data_out holds its value until the next commit. Aborted frames never alter data_out.
- Latency: data_out is valid at the c2 edge immediately after the DATA_WIDTH-th c1 capture. No further wait states.
- Reset mid-frame: all state is cleared immediately, no commit occurs, and the frame is lost.
- busy = (state != IDLE), decoded combinationally from the state register.
- sout = S[0], combinational from the slave register.

Test Plan:
- Reset, then DATA_WIDTH=8 frame 0xA5 sent LSB first (start with bit 0, alternating c1/c2) -> after the 8th c2:
  - data_out = 0xA5;
  - done = 1 for exactly one cycle;
  - busy high from the first c1 to the commit edge, then 0.
- Frame 0x3C, then 3 bits of garbage, then start with 0xF0 -> data_out = 0xF0 after the second frame only; exactly one done pulse for that frame.
- During COMMIT_WAIT, extra c1 pulses, with and without start, with sin=1 -> the committed word is unchanged (0x81 sent gives 0x81); the state returns to IDLE on c2.
- reset asserted after 5 bits of frame 0xFF, previously committed 0x12 -> data_out = 0 immediately, busy = 0, no done pulse. A following frame 0x55 commits 0x55.
- Back-to-back frames 0x01 then 0x80, where start is on the first c1 after the commit c2 -> two done pulses, data_out 0x01 then 0x80; no bit lost.
- Chaining: two instances with sout -> sin, 16 bits shifted, first instance framed, second instance framed at bit 8 -> first instance's sout replays the bits captured 8 pairs earlier; second instance commits the low byte stream.

Source files
------------

// File: rtl/ym_dbg_write.sv
// Serial-in, parallel-out debug write chain: assembles an LSB-first framed
// bit stream under c1/c2 two-phase enables and commits it to data_out.
module ym_dbg_write #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  start,
  input  logic                  sin,
  output logic                  sout,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  capture;
  logic [CW-1:0]         cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, capture/transfer and commit decode
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    s_d        = s_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (c1 && start) begin
          capture = 1'b1;
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (c1) begin
          capture = 1'b1;
          if (start) begin
            cnt_d = CW'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DATA_WIDTH)) begin
              state_d = ST_COMMIT;
            end
          end
        end
      end
      ST_COMMIT: begin
        // c1 is ignored here, start included; only c2 finishes the frame
        if (c2) begin
          data_out_d = m_q;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Both phases on one edge: capture sees old slave, transfer sees old master
    if (capture) begin
      m_d = {sin, s_q[DATA_WIDTH-1:1]};
    end
    if (c2) begin
      s_d = m_q;
    end
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      s_q        <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign sout     = s_q[0];
  assign busy     = (state_q != ST_IDLE);
  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ym_dbg_write.sv
// Scoreboard bench for ym_dbg_write: expected words queued as frames are sent,
// popped and compared whenever done pulses; second instance checks chaining.
module tb_ym_dbg_write;

  logic       clk;
  logic       rst_n;
  logic       c1, c2, start, sin, start_b;
  logic       sout, busy, done;
  logic [7:0] data_out;
  logic       sout_b, busy_b, done_b;
  logic [7:0] data_out_b;

  int n_vec;
  int n_err;
  int n_push;
  int n_done;
  int n_done_b;
  logic [7:0] sb[$];

  ym_dbg_write #(.DATA_WIDTH(8)) u_dut (
    .MCLK(clk), .reset(rst_n), .c1(c1), .c2(c2), .start(start), .sin(sin),
    .sout(sout), .data_out(data_out), .busy(busy), .done(done)
  );

  ym_dbg_write #(.DATA_WIDTH(8)) u_b (
    .MCLK(clk), .reset(rst_n), .c1(c1), .c2(c2), .start(start_b), .sin(sout),
    .sout(sout_b), .data_out(data_out_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued word
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) check("done_spurious", 32'(done), 32'(0));
      else check("sb_data", 32'(data_out), 32'(sb.pop_front()));
    end
    if (rst_n && done_b) n_done_b++;
  end

  task automatic tick(input logic a, input logic b, input logic st, input logic s);
    @(negedge clk);
    c1 = a; c2 = b; start = st; sin = s;
    @(posedge clk);
    #1;
    c1 = 1'b0; c2 = 1'b0; start = 1'b0; sin = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w);
    sb.push_back(w);
    n_push++;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, i == 0, w[i]);
      if (i == 0) begin
        check("busy_first", 32'(busy), 32'(1));
        check("done_low", 32'(done), 32'(0));
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("commit_data", 32'(data_out), 32'(w));
    check("commit_done", 32'(done), 32'(1));
    check("commit_busy", 32'(busy), 32'(0));
  endtask

  task automatic partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, i == 0, w[i]);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] stream;
    n_vec = 0; n_err = 0; n_push = 0; n_done = 0; n_done_b = 0;
    rst_n = 1'b0;
    c1 = 1'b0; c2 = 1'b0; start = 1'b0; sin = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sout", 32'(sout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores c1 without start
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("idle_nostart", 32'(busy), 32'(0));

    send_frame(8'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("done_one_cycle", 32'(done), 32'(0));

    // Full frame, aborted partial frame, then restart mid-frame
    send_frame(8'h3C);
    partial(8'h06, 3);
    check("garbage_busy", 32'(busy), 32'(1));
    check("garbage_hold", 32'(data_out), 32'(8'h3C));
    send_frame(8'hF0);

    // Reset mid-frame wipes everything, no commit
    send_frame(8'h12);
    partial(8'hFF, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_sout", 32'(sout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h55);

    // Extra c1 pulses during COMMIT_WAIT; commit edge also carries c1 & start
    sb.push_back(8'h81);
    n_push++;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, i == 0, i == 0 || i == 7);
      if (i < 7) tick(1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("cw_busy", 32'(busy), 32'(1));
    check("cw_hold", 32'(data_out), 32'(8'h55));
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("cw_data", 32'(data_out), 32'(8'h81));
    check("cw_done", 32'(done), 32'(1));
    check("cw_idle", 32'(busy), 32'(0));
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("cw_after_idle", 32'(busy), 32'(0));
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back frames
    send_frame(8'h01);
    send_frame(8'h80);

    // Chaining: dut framed at bits 0 and 8, u_b framed at bit 8 off dut.sout
    stream = 16'hC35A;
    sb.push_back(8'h5A);
    sb.push_back(8'hC3);
    n_push += 2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k >= 8) check("chain_sout", 32'(sout), 32'(stream[k-8]));
      c1 = 1'b1; start = (k == 0 || k == 8); start_b = (k == 8); sin = stream[k];
      @(posedge clk);
      #1;
      c1 = 1'b0; start = 1'b0; start_b = 1'b0; sin = 1'b0;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("chain_a_data", 32'(data_out), 32'(8'hC3));
    check("chain_b_data", 32'(data_out_b), 32'(8'h5A));
    check("chain_b_busy", 32'(busy_b), 32'(0));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    check("chain_b_pulses", 32'(n_done_b), 32'(1));
    check("done_pulses", 32'(n_done), 32'(n_push));
    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
